// File: rtl/tx_flow_scheduler.sv
// tx_flow_scheduler: round-robin batch scheduler for per-flow TX FIFOs.
// Scans one flow per cycle and grants a flow whose occupancy covers a full
// batch (1, 2 or 4 entries). Once granted, the batch pops for grant_len
// consecutive cycles and cannot be shortened or extended.
// Optional feature: define TX_SCHED_FLUSH_EN to flush partial batches after
// FLUSH_TIMEOUT scan cycles without a grant.
module tx_flow_scheduler #(
  parameter int LMAX_NUM_OF_FLOWS = 3,
  parameter int LTX_FIFO_DEPTH    = 3,
  parameter int FLUSH_TIMEOUT     = 64
) (
  input  logic                                                   clk,
  input  logic                                                   resetn,
  input  logic                                                   start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]                           number_of_flows,
  input  logic [1:0]                                             l_tx_batch_size,
  input  logic [(2**LMAX_NUM_OF_FLOWS)*(LTX_FIFO_DEPTH+1)-1:0]   flow_dw_in,
  input  logic                                                   sRx_c1TxAlmFull,
  output logic [(2**LMAX_NUM_OF_FLOWS)-1:0]                      ff_pop_en,
  output logic                                                   grant_valid,
  output logic [LMAX_NUM_OF_FLOWS-1:0]                           grant_flow,
  output logic [2:0]                                             grant_len,
  output logic                                                   busy,
  output logic [31:0]                                            grant_cnt_out
);

  localparam int unsigned MAX_TX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
  localparam int unsigned DW           = LTX_FIFO_DEPTH + 1;
  localparam int unsigned FW           = LMAX_NUM_OF_FLOWS;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_SCAN = 2'd1,
    SCHED_POP  = 2'd2
  } sched_state_e;

  sched_state_e            state_q, state_d;
  logic [FW-1:0]           scan_ptr_q, scan_ptr_d;
  logic [MAX_TX_FLOWS-1:0] ff_pop_en_q, ff_pop_en_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [FW-1:0]           grant_flow_q, grant_flow_d;
  logic [2:0]              grant_len_q, grant_len_d;
  logic [31:0]             grant_cnt_q, grant_cnt_d;
  logic [2:0]              pop_left_q, pop_left_d;
  logic [FW-1:0]           nflows_q, nflows_d;

  logic [DW-1:0]           dw_arr [MAX_TX_FLOWS];
  logic [DW-1:0]           cur_dw;
  logic [2:0]              batch_len;
  logic                    full_ok;
  logic                    take;
  logic [2:0]              take_len;
  logic [FW-1:0]           scan_next;
  logic [FW-1:0]           after_batch_ptr;

  // Unpack the per-flow occupancy bus
  always_comb begin
    for (int unsigned i = 0; i < MAX_TX_FLOWS; i++) begin
      dw_arr[i] = flow_dw_in[i*DW +: DW];
    end
  end

  // Decode log2 batch size; code 3 is treated as 2 (batch of 4)
  always_comb begin
    case (l_tx_batch_size)
      2'd0:    batch_len = 3'd1;
      2'd1:    batch_len = 3'd2;
      default: batch_len = 3'd4;
    endcase
  end

  assign cur_dw  = dw_arr[scan_ptr_q];
  assign full_ok = ({3'b000, cur_dw} >= {{DW{1'b0}}, batch_len});

  // Pointer wrap uses live flow count while scanning, sampled count after a batch
  assign scan_next       = (scan_ptr_q >= number_of_flows) ? '0 : scan_ptr_q + FW'(1);
  assign after_batch_ptr = (grant_flow_q >= nflows_q) ? '0 : grant_flow_q + FW'(1);

`ifdef TX_SCHED_FLUSH_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        flush_ok;
  logic [2:0]  flush_len;

  // Partial occupancy is below a full batch (at most 3), so the flush length is 1 or 2
  assign flush_ok  = (idle_cnt_q >= 16'(FLUSH_TIMEOUT)) && (cur_dw != '0) && !full_ok;
  assign flush_len = (cur_dw >= DW'(2)) ? 3'd2 : 3'd1;
  assign take      = !sRx_c1TxAlmFull && (full_ok || flush_ok);
  assign take_len  = full_ok ? batch_len : flush_len;

  // Count scan cycles without a grant; saturate rather than wrap
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q == SCHED_SCAN) && start) begin
      if (take) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q != '1) begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end
    end
  end

  // Idle counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign take     = !sRx_c1TxAlmFull && full_ok;
  assign take_len = batch_len;
`endif

  // Next-state and registered-output logic for the scheduler FSM
  always_comb begin
    state_d       = state_q;
    scan_ptr_d    = scan_ptr_q;
    ff_pop_en_d   = ff_pop_en_q;
    grant_valid_d = 1'b0;
    grant_flow_d  = grant_flow_q;
    grant_len_d   = grant_len_q;
    grant_cnt_d   = grant_cnt_q;
    pop_left_d    = pop_left_q;
    nflows_d      = nflows_q;
    case (state_q)
      SCHED_IDLE: begin
        if (start) begin
          state_d = SCHED_SCAN;
        end
      end
      SCHED_SCAN: begin
        if (!start) begin
          state_d = SCHED_IDLE;
        end else if (take) begin
          state_d                 = SCHED_POP;
          grant_valid_d           = 1'b1;
          grant_flow_d            = scan_ptr_q;
          grant_len_d             = take_len;
          ff_pop_en_d             = '0;
          ff_pop_en_d[scan_ptr_q] = 1'b1;
          pop_left_d              = take_len - 3'd1;
          grant_cnt_d             = grant_cnt_q + 32'd1;
          nflows_d                = number_of_flows;
        end else begin
          scan_ptr_d = scan_next;
        end
      end
      SCHED_POP: begin
        if (pop_left_q == 3'd0) begin
          ff_pop_en_d = '0;
          scan_ptr_d  = after_batch_ptr;
          state_d     = start ? SCHED_SCAN : SCHED_IDLE;
        end else begin
          pop_left_d = pop_left_q - 3'd1;
        end
      end
      default: begin
        state_d     = SCHED_IDLE;
        ff_pop_en_d = '0;
      end
    endcase
  end

  // Scheduler state and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= SCHED_IDLE;
      scan_ptr_q    <= '0;
      ff_pop_en_q   <= '0;
      grant_valid_q <= 1'b0;
      grant_flow_q  <= '0;
      grant_len_q   <= 3'd1;
      grant_cnt_q   <= '0;
      pop_left_q    <= '0;
      nflows_q      <= '0;
    end else begin
      state_q       <= state_d;
      scan_ptr_q    <= scan_ptr_d;
      ff_pop_en_q   <= ff_pop_en_d;
      grant_valid_q <= grant_valid_d;
      grant_flow_q  <= grant_flow_d;
      grant_len_q   <= grant_len_d;
      grant_cnt_q   <= grant_cnt_d;
      pop_left_q    <= pop_left_d;
      nflows_q      <= nflows_d;
    end
  end

  assign ff_pop_en     = ff_pop_en_q;
  assign grant_valid   = grant_valid_q;
  assign grant_flow    = grant_flow_q;
  assign grant_len     = grant_len_q;
  assign busy          = (state_q == SCHED_POP);
  assign grant_cnt_out = grant_cnt_q;

endmodule

// File: doc/tx_flow_scheduler.md
TX_FLOW_SCHEDULER -- requirements
Module: tx_flow_scheduler

Interface
REQ-001 The module SHALL take parameter LMAX_NUM_OF_FLOWS, default 3; log2 of the flow count, with MAX_TX_FLOWS = 2**LMAX_NUM_OF_FLOWS.
REQ-002 The module SHALL take parameter LTX_FIFO_DEPTH, default 3; log2 of the per-flow FIFO depth, with occupancy width DW = LTX_FIFO_DEPTH+1.
REQ-003 The module SHALL take parameter FLUSH_TIMEOUT, default 64; idle cycles before a partial-batch flush, used only with REQ-027.
REQ-004 The module SHALL have the port clk, input, 1 bit; the single clock.
REQ-005 The module SHALL have the port resetn, input, 1 bit; asynchronous, active-low reset.
REQ-006 The module SHALL have the port start, input, 1 bit; scheduler enable.
REQ-007 The module SHALL have the port number_of_flows, input, LMAX_NUM_OF_FLOWS bits; highest active flow index.
REQ-008 The module SHALL have the port l_tx_batch_size, input, 2 bits; log2 batch size, with 3 treated as 2.
REQ-009 The module SHALL have the port flow_dw_in, input, MAX_TX_FLOWS*DW bits; packed per-flow FIFO occupancy, flow i at bits [i*DW +: DW].
REQ-010 The module SHALL have the port sRx_c1TxAlmFull, input, 1 bit; CCI-P TX almost-full.
REQ-011 The module SHALL have the port ff_pop_en, output, MAX_TX_FLOWS bits; per-flow pop strobe, at most one bit high per cycle.
REQ-012 The module SHALL have the port grant_valid, output, 1 bit; one-cycle pulse marking the start of a batch.
REQ-013 The module SHALL have the port grant_flow, output, LMAX_NUM_OF_FLOWS bits; flow of the current batch, held until the next grant.
REQ-014 The module SHALL have the port grant_len, output, 3 bits; entries in the current batch (1, 2 or 4), held until the next grant.
REQ-015 The module SHALL have the port busy, output, 1 bit; high while in SCHED_POP.
REQ-016 The module SHALL have the port grant_cnt_out, output, 32 bits; total grants issued, wrapping.

Function
REQ-017 The module SHALL implement states SCHED_IDLE, SCHED_SCAN and SCHED_POP, all registered.
REQ-018 SCHED_IDLE SHALL go to SCHED_SCAN on the first cycle start is high, and SHALL otherwise hold.
REQ-019 SCHED_SCAN SHALL examine one flow per cycle at scan_ptr. If flow_dw[scan_ptr] >= batch and sRx_c1TxAlmFull is low, the module SHALL grant that flow and enter SCHED_POP. Otherwise scan_ptr SHALL advance by one.
REQ-020 scan_ptr SHALL wrap to 0 after reaching number_of_flows. A scan_ptr greater than number_of_flows (after a config change) SHALL wrap to 0 on the next advance.
REQ-021 On the grant edge, the module SHALL register grant_valid=1, grant_flow, grant_len, and ff_pop_en[flow]=1 in the same cycle.
REQ-022 SCHED_POP SHALL assert ff_pop_en[flow] for exactly grant_len consecutive cycles, including the grant cycle, then return to SCHED_SCAN with scan_ptr = flow+1 (wrapped), giving round-robin fairness.
REQ-023 A batch SHALL be atomic: sRx_c1TxAlmFull, start deassertion and config changes SHALL NOT shorten or extend a batch in progress. If start is low at batch end, the next state SHALL be SCHED_IDLE.
REQ-024 start low in SCHED_SCAN SHALL return the module to SCHED_IDLE on the next cycle, with scan_ptr retained.
REQ-025 Batch size and number_of_flows SHALL be sampled into registers at grant; mid-batch changes SHALL take effect at the next grant.
REQ-026 grant_cnt_out SHALL increment by 1 per grant and wrap from 2**32-1 to 0.

Configuration
REQ-027 With macro TX_SCHED_FLUSH_EN defined, a 16-bit idle counter SHALL count SCHED_SCAN cycles without a grant. When it reaches FLUSH_TIMEOUT and the flow at scan_ptr has 0 < dw < batch with sRx_c1TxAlmFull low, the module SHALL grant that flow with grant_len = the largest power of two <= dw. The counter SHALL clear on any grant.
REQ-028 Without TX_SCHED_FLUSH_EN, the counter and flush logic SHALL be absent, and partial batches SHALL never be granted.

Reset
REQ-029 Asserting resetn low SHALL immediately and asynchronously set: state=SCHED_IDLE, scan_ptr=0, ff_pop_en=0, grant_valid=0, grant_flow=0, grant_len=1, busy=0, grant_cnt_out=0, idle counter=0.
REQ-030 Reset asserted during SCHED_POP SHALL abort the batch with no further pop strobes. Operation SHALL resume only after resetn is high and start is high.

Verification
REQ-031 The bench SHALL cover this case. Stimulus: 4 flows, batch 4, flow 2 dw=4, others 0, start=1. Required response: one grant (flow 2, len 4), ff_pop_en[2] high for exactly 4 cycles, grant_cnt_out=1.
REQ-032 The bench SHALL cover this case. Stimulus: all 4 flows dw=8, batch 2. Required response: grants in order 0,1,2,3,0, each with 2 pop cycles and no idle gap beyond 1 scan cycle.
REQ-033 The bench SHALL cover this case. Stimulus: sRx_c1TxAlmFull=1 with flow 0 dw=4, then raise sRx_c1TxAlmFull mid-batch on a later grant. Required response: no grant while almost-full is high; a batch already started completes all 4 pops.
REQ-034 The bench SHALL cover this case. Stimulus: resetn low at the 2nd pop cycle of a batch of 4. Required response: ff_pop_en=0 in the same cycle, state IDLE, all outputs at reset values.
REQ-035 The bench SHALL cover this case. Stimulus: TX_SCHED_FLUSH_EN defined, FLUSH_TIMEOUT=64, batch 4, flow 1 dw=3. Required response: grant (flow 1, len 2) 64 scan cycles after scan start. Without the macro: no grant.
REQ-036 The bench SHALL cover this case. Stimulus: number_of_flows changed from 7 to 1 while scan_ptr=5. Required response: scan_ptr wraps to 0, and only flows 0 and 1 are granted thereafter.
